diag_vram_fetch: RTL
====================

# diag_vram_fetch

SPI master that pulls video RAM contents out of a ROMulator board over the diagnostics SPI link, for on-FPGA consumers such as a local display mirror or a second-board monitor. It issues the READ_VRAM command (0x88) and receives VRAM bytes in groups of eight. Each group is followed by a parity byte, which the block checks; it answers every group with a status byte. Verified bytes are written into a local buffer; a group that fails parity is NAKed with PARITY_ERROR (0x22) and received again.

## Interface
- CLK_DIV, 4: fpga_clk cycles per spi_clk half-period (≥2).
- GAP_CYCLES, 16: idle fpga_clk cycles between bytes, spi_select held low.
- MAX_RETRIES, 3: consecutive NAKs allowed on one group before abort.

- fpga_clk  in  1  system clock; one clock domain.
- fpga_reset  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; ignored while busy.
- vram_size  in  11  byte count to fetch, sampled on start.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse, fetch completed.
- error  out  1  one-cycle pulse, aborted after retries exhausted.
- retry_count  out  8  total NAKs this fetch, saturating at 255.
- spi_clk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
- spi_mosi  out  1  master data out.
- spi_miso  in  1  slave data in.
- spi_select  out  1  chip select, active-low.
- buf_addr  out  11  local buffer write address.
- buf_data  out  8  local buffer write data.
- buf_we  out  1  buffer write strobe, one cycle per byte.

## Operation
- Reset values:
  - spi_select=1, spi_clk=0, spi_mosi=0.
  - busy=0, done=0, error=0, buf_we=0, buf_addr=0, buf_data=0, retry_count=0.
  - FSM=IDLE.
- Effective length L = vram_size & ~7, rounded down to a multiple of 8.
  - L=0: done pulses the cycle after start, busy stays 0, no SPI activity.
- Byte engine: shifts one byte; MOSI out and MISO in are MSB first.
  - MOSI is driven before the first rising edge and updated on each falling edge.
  - MISO is sampled on each rising edge.
  - After the 8th falling edge, spi_clk stays low for GAP_CYCLES, then the next byte starts.
- FSM:
  - IDLE → CMD on accepted start: latch L, group_base=0, retry_count=0, spi_select=0.
  - CMD: send 0x88; received byte discarded → DATA.
  - DATA: send 0x00 ×8; received byte i goes to stage[i], parity bit p[i] = XOR of its 8 bits → PARITY.
  - PARITY: send 0x00; received byte compared with p[7:0] → STATUS.
  - STATUS, match: send 0x00, clear per-group retry counter → COMMIT.
  - STATUS, mismatch, per-group retries < MAX_RETRIES: send 0x22, increment both counters → DATA; stage discarded, group_base unchanged.
  - STATUS, mismatch, per-group retries = MAX_RETRIES: → FAIL.
  - COMMIT: 8 consecutive cycles with buf_we=1, buf_addr=group_base+i, buf_data=stage[i].
    - Then group_base += 8.
    - If group_base = L → DONE, else → DATA.
  - DONE: spi_select=1, done pulse, busy=0 → IDLE.
  - FAIL: spi_select=1, error pulse, busy=0 → IDLE.
    - Buffer keeps the groups committed before the failing group.
- Buffer addresses wrap at 2048; L ≤ 2040, so no wrap occurs within a fetch.
- retry_count holds its value after done/error until the next accepted start.

## Timing
- One byte = 16·CLK_DIV + GAP_CYCLES fpga_clk cycles.
- Group with no error = 10 bytes + 8 commit cycles.
- Full fetch = 1 + 10·(L/8) bytes plus commit cycles plus 2 cycles of start/done overhead.
- spi_select falls 1 cycle after start and stays low through the last STATUS byte.
  - It rises in the DONE/FAIL cycle, in the same cycle as the done/error pulse.
- spi_select is never deasserted between bytes.
- buf_we is never asserted for a group that failed parity.
- start arriving in the same cycle as done/error is ignored.
- Reset asserted mid-fetch: all outputs go to reset values immediately (asynchronous), including spi_select=1 and spi_clk=0.
  - No partial buf_we is issued.
  - After reset release, FSM is IDLE.

## Test plan
- vram_size=16, slave model returns 0x00..0x0F with correct parity → MOSI sequence 0x88, then per group 0x00 ×10; buf addr 0..15 = 0x00..0x0F; done at end; retry_count=0.
- Group 0 = 0x01,0x03,0xFF,0x80,0,0,0,0; parity 0x09 (correct) → accepted. Same data with parity byte 0x00 → STATUS byte 0x22, group resent and committed once, retry_count=1.
- Slave always sends parity 0xFF with zero data, MAX_RETRIES=3 → four 0x22-or-fail cycles on group 0, error pulse, no buf_we, spi_select=1.
- vram_size=5 → done the next cycle, spi_select never falls; vram_size=0x7FF → L=2040, last write at buf_addr 2039.
- fpga_reset pulled low mid DATA byte of group 3 → spi_select=1 and spi_clk=0 immediately, busy=0; a new start fetches from group_base 0.
- start held high during a fetch → single fetch, no restart; CLK_DIV=2, GAP_CYCLES=16: measured per-byte period is 48 cycles.

Source files
------------

// File: rtl/diag_vram_fetch.sv
// diag_vram_fetch
//
// SPI master that pulls VRAM contents from a ROMulator board over the
// diagnostics link. It sends READ_VRAM (0x88), then receives the data in
// groups of eight bytes. Each group is followed by one parity byte, and the
// master answers each group with one status byte. Verified groups are written
// into a local buffer. A group whose parity does not match is NAKed with 0x22
// and received again, up to MAX_RETRIES times in a row.
//
// Ports
//   fpga_clk, fpga_reset    clock and asynchronous active-low reset
//   start, vram_size        one-cycle fetch request and byte count (sampled on start)
//   busy, done, error       fetch in progress, completion pulse, abort pulse
//   retry_count             total NAKs in this fetch, saturating at 255
//   spi_clk/mosi/miso/select SPI mode 0, MSB first, active-low select
//   buf_addr/data/we        local buffer write port, one strobe per byte
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_CMD    | shifting the READ_VRAM command; the received byte is dropped
// S_DATA   | shifting 8 dummy bytes and capturing the group into stage[]
// S_PARITY | shifting 1 dummy byte and capturing the slave's parity byte
// S_STATUS | shifting ACK (0x00) or NAK (0x22), then deciding what comes next
// S_COMMIT | 8 cycles writing stage[] into the buffer
// S_DONE   | select released, done pulse
// S_FAIL   | select released, error pulse
module diag_vram_fetch #(
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_RETRIES = 3
) (
    input  logic        fpga_clk,
    input  logic        fpga_reset,
    input  logic        start,
    input  logic [10:0] vram_size,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  retry_count,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_select,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        buf_we
);

    localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRIES + 2);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [7:0]    CMD_READ  = 8'h88;
    localparam logic [7:0]    NAK       = 8'h22;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_PARITY, S_STATUS, S_COMMIT, S_DONE, S_FAIL
    } state_t;

    state_t state, next_state;

    // byte engine
    logic          eng_busy, eng_gap, eng_load, byte_last;
    logic [3:0]    half_idx;
    logic [TW-1:0] tmr;
    logic [7:0]    tx_shift, rx_shift, eng_tx;

    // fetch bookkeeping
    logic [10:0]   len, group_base;
    logic [2:0]    byte_idx, commit_idx;
    logic [7:0]    stage [8];
    logic [7:0]    p_bits;
    logic          par_bad, par_mis;
    logic [RW-1:0] grp_retries;
    logic [10:0]   len_in;

    function automatic logic is_byte_state(state_t s);
        return s inside {S_CMD, S_DATA, S_PARITY, S_STATUS};
    endfunction

    function automatic logic is_active(state_t s);
        return s inside {S_CMD, S_DATA, S_PARITY, S_STATUS, S_COMMIT};
    endfunction

    assign len_in    = vram_size & 11'h7F8;
    assign byte_last = eng_busy && eng_gap && (tmr == '0);
    assign par_mis   = (rx_shift != p_bits);

    always_comb begin
        next_state = state;
        eng_tx     = 8'h00;
        case (state)
            S_IDLE:   if (start) next_state = (len_in == '0) ? S_DONE : S_CMD;
            S_CMD:    if (byte_last) next_state = S_DATA;
            S_DATA:   if (byte_last && byte_idx == 3'd7) next_state = S_PARITY;
            S_PARITY: if (byte_last) next_state = S_STATUS;
            S_STATUS: if (byte_last) begin
                if (!par_bad)                      next_state = S_COMMIT;
                else if (grp_retries < RETRY_MAX)  next_state = S_DATA;
                else                               next_state = S_FAIL;
            end
            S_COMMIT: if (commit_idx == 3'd7)
                next_state = (group_base + 11'd8 == len) ? S_DONE : S_DATA;
            S_DONE:   next_state = S_IDLE;
            S_FAIL:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        // A new byte starts when entering a byte state, or back-to-back when
        // the current byte ends and another byte state follows.
        eng_load = is_byte_state(next_state) && (!is_byte_state(state) || byte_last);
        // The status byte is chosen at the end of the parity byte, so the
        // compare is taken straight from the shift register.
        if (next_state == S_CMD)
            eng_tx = CMD_READ;
        else if (next_state == S_STATUS && par_mis)
            eng_tx = NAK;
    end

    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            eng_busy <= 1'b0;
            eng_gap  <= 1'b0;
            half_idx <= '0;
            tmr      <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (eng_load) begin
            eng_busy <= 1'b1;
            eng_gap  <= 1'b0;
            half_idx <= '0;
            tmr      <= HALF_LOAD;
            spi_clk  <= 1'b0;
            spi_mosi <= eng_tx[7];
            tx_shift <= {eng_tx[6:0], 1'b0};
        end else if (eng_busy) begin
            if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end else if (eng_gap) begin
                eng_busy <= 1'b0;
                eng_gap  <= 1'b0;
            end else if (!half_idx[0]) begin
                spi_clk  <= 1'b1;
                rx_shift <= {rx_shift[6:0], spi_miso};
                tmr      <= HALF_LOAD;
                half_idx <= half_idx + 4'd1;
            end else begin
                spi_clk  <= 1'b0;
                spi_mosi <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                half_idx <= half_idx + 4'd1;
                if (half_idx == 4'd15) begin
                    eng_gap <= 1'b1;
                    tmr     <= GAP_LOAD;
                end else begin
                    tmr <= HALF_LOAD;
                end
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            state       <= S_IDLE;
            spi_select  <= 1'b1;
            len         <= '0;
            group_base  <= '0;
            byte_idx    <= '0;
            commit_idx  <= '0;
            p_bits      <= '0;
            par_bad     <= 1'b0;
            grp_retries <= '0;
            retry_count <= '0;
            for (int i = 0; i < 8; i++) stage[i] <= '0;
        end else begin
            state      <= next_state;
            spi_select <= !is_active(next_state);
            case (state)
                S_IDLE: if (start) begin
                    len         <= len_in;
                    group_base  <= '0;
                    byte_idx    <= '0;
                    commit_idx  <= '0;
                    grp_retries <= '0;
                    retry_count <= '0;
                end
                S_DATA: if (byte_last) begin
                    stage[byte_idx]  <= rx_shift;
                    p_bits[byte_idx] <= ^rx_shift;
                    byte_idx         <= byte_idx + 3'd1;
                end
                S_PARITY: if (byte_last) par_bad <= par_mis;
                S_STATUS: if (byte_last) begin
                    if (!par_bad) begin
                        grp_retries <= '0;
                        commit_idx  <= '0;
                    end else if (grp_retries < RETRY_MAX) begin
                        grp_retries <= grp_retries + 1'b1;
                        if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
                    end
                end
                S_COMMIT: begin
                    commit_idx <= commit_idx + 3'd1;
                    if (commit_idx == 3'd7) group_base <= group_base + 11'd8;
                end
                default: ;
            endcase
        end
    end

    assign busy     = is_active(state);
    assign done     = (state == S_DONE);
    assign error    = (state == S_FAIL);
    assign buf_we   = (state == S_COMMIT);
    assign buf_addr = buf_we ? group_base + {8'd0, commit_idx} : 11'd0;
    assign buf_data = buf_we ? stage[commit_idx] : 8'd0;

endmodule
